// File: rtl/multi_ch_dds_pkg.sv
// Shared definitions for the multi-channel quadrature DDS: config select
// encoding, pipeline latency, channel index width and quarter-wave table contents.
package dds_pkg;

    localparam logic CFG_FREQ  = 1'b0;
    localparam logic CFG_PHASE = 1'b1;

    // Slot-to-output latency in enabled clocks.
    localparam int LAT = 4;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One quarter-wave entry: round(A*sin(2*pi*(k+0.5)/2^aw)), A = 2^(dw-1)-1.
    // The half-step offset makes the table symmetric, so mirroring and negation
    // reproduce the full wave exactly. The angle stays below pi/2, where a short
    // Taylor series is accurate far beyond one LSB.
    function automatic int quarter_sine_entry(input int k, input int aw, input int dw);
        real x;
        real term;
        real sum;
        real amp;
        x    = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(1 << aw);
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        amp = real'((1 << (dw - 1)) - 1);
        return $rtoi(amp * sum + 0.5);
    endfunction

endpackage

// File: rtl/multi_ch_dds_quarter_sine_rom.sv
// Quarter-wave sine table with two independent registered read ports, one for
// the sine path and one for the cosine path of the shared DDS pipeline.
module quarter_sine_rom
    import dds_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = 12
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic [AW-3:0] i_addr_a,
    input  logic [AW-3:0] i_addr_b,
    output logic [DW-1:0] o_data_a,
    output logic [DW-1:0] o_data_b
);

    localparam int DEPTH = 1 << (AW - 2);

    logic [DW-1:0] w_rom [DEPTH];
    logic [DW-1:0] r_data_a;
    logic [DW-1:0] r_data_b;

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign w_rom[k] = DW'(quarter_sine_entry(k, AW, DW));
    end

    // Registered reads; both ports hold while the pipeline is stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data_a <= '0;
            r_data_b <= '0;
        end else if (i_en) begin
            r_data_a <= w_rom[i_addr_a];
            r_data_b <= w_rom[i_addr_b];
        end
    end

    assign o_data_a = r_data_a;
    assign o_data_b = r_data_b;

endmodule

// File: rtl/multi_ch_dds.sv
// Time-multiplexed quadrature DDS: NCH phase accumulators share one quarter-wave
// table and a four-stage pipeline, one channel slot per enabled clock.
// Frequency/phase words are double-buffered and swap in at a frame boundary.
module multi_ch_dds
    import dds_pkg::*;
#(
    parameter int NCH = 4,
    parameter int PW  = 32,
    parameter int AW  = 12,
    parameter int DW  = 12
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_en,
    input  logic                      i_cfg_we,
    input  logic [$clog2(NCH)-1:0]    i_cfg_ch,
    input  logic                      i_cfg_sel,
    input  logic [PW-1:0]             i_cfg_data,
    input  logic                      i_commit,
    input  logic [NCH-1:0]            i_phase_rst,
    output logic                      o_commit_busy,
    output logic                      o_out_valid,
    output logic [$clog2(NCH)-1:0]    o_out_ch,
    output logic signed [DW-1:0]      o_sin,
    output logic signed [DW-1:0]      o_cos
);

    localparam int              CHW     = ch_width(NCH);
    localparam logic [CHW-1:0]  LAST_CH = CHW'(NCH - 1);
    localparam logic [AW-1:0]   QTR     = AW'(1) << (AW - 2);

    // Channel sequencing and per-channel state
    logic [CHW-1:0] r_ch_cnt;
    logic [PW-1:0]  r_acc       [NCH];
    logic [PW-1:0]  r_freq_act  [NCH];
    logic [PW-1:0]  r_phase_act [NCH];
    logic [PW-1:0]  r_freq_sh   [NCH];
    logic [PW-1:0]  r_phase_sh  [NCH];
    logic [PW-1:0]  w_freq_sh_nx  [NCH];
    logic [PW-1:0]  w_phase_sh_nx [NCH];

    // Commit bookkeeping
    logic           r_pending;
    logic [NCH-1:0] r_mask;
    logic [NCH-1:0] r_frame_mask;
    logic [NCH-1:0] w_mask;
    logic           w_apply;
    logic           w_clr;
    logic           w_cfg_ok;
    logic [PW-1:0]  w_freq_cur;
    logic [PW-1:0]  w_phase_cur;

    // Pipeline stages
    logic [PW-1:0]  r_s1_ph;
    logic [CHW-1:0] r_s1_ch;
    logic           r_s1_v;
    logic [AW-1:0]  w_sin_idx;
    logic [AW-1:0]  w_cos_idx;
    logic [AW-3:0]  r_s2_sin_addr;
    logic [AW-3:0]  r_s2_cos_addr;
    logic           r_s2_sin_neg;
    logic           r_s2_cos_neg;
    logic [CHW-1:0] r_s2_ch;
    logic           r_s2_v;
    logic [DW-1:0]  w_rom_sin;
    logic [DW-1:0]  w_rom_cos;
    logic           r_s3_sin_neg;
    logic           r_s3_cos_neg;
    logic [CHW-1:0] r_s3_ch;
    logic           r_s3_v;
    logic                  r_out_valid;
    logic [CHW-1:0]        r_out_ch;
    logic signed [DW-1:0]  r_sin;
    logic signed [DW-1:0]  r_cos;

    // Phase bits below table resolution only matter as carry into the index.
    logic w_unused_ph_lsb;
    assign w_unused_ph_lsb = ^r_s1_ph[PW-AW-1:0];

    assign w_cfg_ok    = int'(i_cfg_ch) < NCH;
    assign w_apply     = i_en && (r_ch_cnt == '0) && (r_pending || i_commit);
    assign w_mask      = i_commit ? i_phase_rst : r_mask;
    assign w_freq_cur  = w_apply ? w_freq_sh_nx[r_ch_cnt]  : r_freq_act[r_ch_cnt];
    assign w_phase_cur = w_apply ? w_phase_sh_nx[r_ch_cnt] : r_phase_act[r_ch_cnt];
    assign w_clr       = w_apply ? w_mask[r_ch_cnt]
                                 : ((r_ch_cnt != '0) && r_frame_mask[r_ch_cnt]);

    // Shadow contents including this cycle's write, so an apply sees it too.
    always_comb begin
        w_freq_sh_nx  = r_freq_sh;
        w_phase_sh_nx = r_phase_sh;
        if (i_cfg_we && w_cfg_ok) begin
            if (i_cfg_sel == CFG_PHASE) w_phase_sh_nx[i_cfg_ch] = i_cfg_data;
            else                        w_freq_sh_nx[i_cfg_ch]  = i_cfg_data;
        end
    end

    // Round-robin slot counter, frozen while disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  r_ch_cnt <= '0;
        else if (i_en) r_ch_cnt <= (r_ch_cnt == LAST_CH) ? '0 : r_ch_cnt + CHW'(1);
    end

    // Shadow registers take host writes at any time, independent of enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                r_freq_sh[c]  <= '0;
                r_phase_sh[c] <= '0;
            end
        end else begin
            r_freq_sh  <= w_freq_sh_nx;
            r_phase_sh <= w_phase_sh_nx;
        end
    end

    // Active words change all at once at the start of a frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                r_freq_act[c]  <= '0;
                r_phase_act[c] <= '0;
            end
        end else if (w_apply) begin
            r_freq_act  <= w_freq_sh_nx;
            r_phase_act <= w_phase_sh_nx;
        end
    end

    // Pending commit and restart mask; the frame mask clears each channel at its own slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending    <= 1'b0;
            r_mask       <= '0;
            r_frame_mask <= '0;
        end else if (w_apply) begin
            r_pending    <= 1'b0;
            r_mask       <= '0;
            r_frame_mask <= w_mask;
        end else begin
            if (i_commit) begin
                r_pending <= 1'b1;
                r_mask    <= i_phase_rst;
            end
            if (i_en) r_frame_mask[r_ch_cnt] <= 1'b0;
        end
    end

    // Advance the slotted channel's accumulator, or restart it when masked.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
        end else if (i_en) begin
            r_acc[r_ch_cnt] <= w_clr ? '0 : r_acc[r_ch_cnt] + w_freq_cur;
        end
    end

    // S1: pre-advance accumulator plus phase offset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_ph <= '0;
            r_s1_ch <= '0;
            r_s1_v  <= 1'b0;
        end else if (i_en) begin
            r_s1_ph <= r_acc[r_ch_cnt] + w_phase_cur;
            r_s1_ch <= r_ch_cnt;
            r_s1_v  <= 1'b1;
        end
    end

    assign w_sin_idx = r_s1_ph[PW-1 -: AW];
    assign w_cos_idx = w_sin_idx + QTR;

    // S2: fold each full-cycle index onto the quarter table (mirror on odd quadrants).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2_sin_addr <= '0;
            r_s2_cos_addr <= '0;
            r_s2_sin_neg  <= 1'b0;
            r_s2_cos_neg  <= 1'b0;
            r_s2_ch       <= '0;
            r_s2_v        <= 1'b0;
        end else if (i_en) begin
            r_s2_sin_addr <= w_sin_idx[AW-2] ? ~w_sin_idx[AW-3:0] : w_sin_idx[AW-3:0];
            r_s2_cos_addr <= w_cos_idx[AW-2] ? ~w_cos_idx[AW-3:0] : w_cos_idx[AW-3:0];
            r_s2_sin_neg  <= w_sin_idx[AW-1];
            r_s2_cos_neg  <= w_cos_idx[AW-1];
            r_s2_ch       <= r_s1_ch;
            r_s2_v        <= r_s1_v;
        end
    end

    quarter_sine_rom #(
        .AW (AW),
        .DW (DW)
    ) u_rom (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (i_en),
        .i_addr_a (r_s2_sin_addr),
        .i_addr_b (r_s2_cos_addr),
        .o_data_a (w_rom_sin),
        .o_data_b (w_rom_cos)
    );

    // S3: sideband travelling alongside the table read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s3_sin_neg <= 1'b0;
            r_s3_cos_neg <= 1'b0;
            r_s3_ch      <= '0;
            r_s3_v       <= 1'b0;
        end else if (i_en) begin
            r_s3_sin_neg <= r_s2_sin_neg;
            r_s3_cos_neg <= r_s2_cos_neg;
            r_s3_ch      <= r_s2_ch;
            r_s3_v       <= r_s2_v;
        end
    end

    // S4: apply sign and present the sample; data holds across stalls and fill.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_sin       <= '0;
            r_cos       <= '0;
        end else if (i_en) begin
            r_out_valid <= r_s3_v;
            if (r_s3_v) begin
                r_out_ch <= r_s3_ch;
                r_sin    <= r_s3_sin_neg ? -$signed(w_rom_sin) : $signed(w_rom_sin);
                r_cos    <= r_s3_cos_neg ? -$signed(w_rom_cos) : $signed(w_rom_cos);
            end
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_commit_busy = r_pending;
    assign o_out_valid   = r_out_valid;
    assign o_out_ch      = r_out_ch;
    assign o_sin         = r_sin;
    assign o_cos         = r_cos;

endmodule

// File: tb/tb_multi_ch_dds.sv
// Self-checking bench for multi_ch_dds: directed scenarios followed by random
// traffic, compared against a frame-level behavioural model with a real-valued sine.
module tb_multi_ch_dds;
    import dds_pkg::*;

    localparam int  NCH  = 4;
    localparam int  PW   = 32;
    localparam int  AW   = 10;
    localparam int  DW   = 12;
    localparam int  NTAB = 1 << AW;
    localparam real AMP  = 2047.0;
    localparam real PI   = 3.14159265358979323846;

    logic                 clk;
    logic                 rstN;
    logic                 en;
    logic                 cfgWe;
    logic [1:0]           cfgCh;
    logic                 cfgSel;
    logic [PW-1:0]        cfgData;
    logic                 commit;
    logic [NCH-1:0]       phaseRst;
    logic                 commitBusy;
    logic                 outValid;
    logic [1:0]           outCh;
    logic signed [DW-1:0] sinOut;
    logic signed [DW-1:0] cosOut;

    multi_ch_dds #(.NCH(NCH), .PW(PW), .AW(AW), .DW(DW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_en          (en),
        .i_cfg_we      (cfgWe),
        .i_cfg_ch      (cfgCh),
        .i_cfg_sel     (cfgSel),
        .i_cfg_data    (cfgData),
        .i_commit      (commit),
        .i_phase_rst   (phaseRst),
        .o_commit_busy (commitBusy),
        .o_out_valid   (outValid),
        .o_out_ch      (outCh),
        .o_sin         (sinOut),
        .o_cos         (cosOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int s;
        int c;
    } sample_t;

    // Reference model state, kept at the level of words, frames and samples
    logic [PW-1:0]  mAcc   [NCH];
    logic [PW-1:0]  mFAct  [NCH];
    logic [PW-1:0]  mPAct  [NCH];
    logic [PW-1:0]  mFSh   [NCH];
    logic [PW-1:0]  mPSh   [NCH];
    bit             mRestart [NCH];
    bit             mPending;
    logic [NCH-1:0] mMask;
    int             mSlot;
    sample_t        pipeQ[$];
    bit             expValid;
    sample_t        expOut;

    int nVec;
    int nFail;

    // Ideal table sample at a full-cycle index, rounded half away from zero.
    function automatic int refSine(input int idx);
        real a;
        a = AMP * $sin(2.0 * PI * (real'(idx) + 0.5) / real'(NTAB));
        return (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(-a + 0.5);
    endfunction

    task automatic modelReset();
        for (int c = 0; c < NCH; c++) begin
            mAcc[c] = '0; mFAct[c] = '0; mPAct[c] = '0;
            mFSh[c] = '0; mPSh[c] = '0; mRestart[c] = 1'b0;
        end
        mPending = 1'b0;
        mMask    = '0;
        mSlot    = 0;
        pipeQ.delete();
        expValid = 1'b0;
        expOut   = '{0, 0, 0};
    endtask

    // One clock edge of the reference behaviour, using the inputs currently driven.
    task automatic modelEdge();
        bit             applyNow;
        logic [NCH-1:0] m;
        logic [PW-1:0]  ph;
        int             idx;
        sample_t        smp;
        if (cfgWe) begin
            if (cfgSel == CFG_PHASE) mPSh[cfgCh] = cfgData;
            else                     mFSh[cfgCh] = cfgData;
        end
        applyNow = en && (mSlot == 0) && (mPending || commit);
        if (applyNow) begin
            m = commit ? phaseRst : mMask;
            for (int c = 0; c < NCH; c++) begin
                mFAct[c]    = mFSh[c];
                mPAct[c]    = mPSh[c];
                mRestart[c] = m[c];
            end
            mPending = 1'b0;
        end else if (commit) begin
            mPending = 1'b1;
            mMask    = phaseRst;
        end
        if (en) begin
            ph          = mAcc[mSlot] + mPAct[mSlot];
            mAcc[mSlot] = mRestart[mSlot] ? '0 : mAcc[mSlot] + mFAct[mSlot];
            mRestart[mSlot] = 1'b0;
            idx = int'(ph[PW-1 -: AW]);
            smp = '{mSlot, refSine(idx), refSine((idx + NTAB / 4) % NTAB)};
            pipeQ.push_back(smp);
            if (pipeQ.size() == LAT) begin
                expOut   = pipeQ.pop_front();
                expValid = 1'b1;
            end else begin
                expValid = 1'b0;
            end
            mSlot = (mSlot + 1) % NCH;
        end else begin
            expValid = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        nVec++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        checkOutput("out_valid", outValid, expValid);
        checkOutput("commit_busy", commitBusy, mPending);
        if (expValid) begin
            checkOutput("out_ch", outCh, expOut.ch);
            checkOutput("sin", sinOut, expOut.s);
            checkOutput("cos", cosOut, expOut.c);
        end
    endtask

    // Drive one cycle's inputs, clock it, step the model and check just after the edge.
    task automatic applyStimulus(input bit e, input bit we, input int ch, input bit sel,
                                 input logic [PW-1:0] d, input bit cm,
                                 input logic [NCH-1:0] pr);
        en       = e;
        cfgWe    = we;
        cfgCh    = 2'(ch);
        cfgSel   = sel;
        cfgData  = d;
        commit   = cm;
        phaseRst = pr;
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 0, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        nVec = 0;
        nFail = 0;
        rstN = 1'b0;
        en = 1'b0; cfgWe = 1'b0; cfgCh = '0; cfgSel = 1'b0;
        cfgData = '0; commit = 1'b0; phaseRst = '0;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", outValid, 0);
        checkOutput("rst_busy", commitBusy, 0);
        checkOutput("rst_ch", outCh, 0);
        checkOutput("rst_sin", sinOut, 0);
        checkOutput("rst_cos", cosOut, 0);
        rstN = 1'b1;

        $display("[TB] step 1: free run with zero words");
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, 1'b0, 0, 1'b0, '0, 1'b0, '0);
            if (outValid) begin
                checkOutput("idle_sin", sinOut, 6);
                checkOutput("idle_cos", cosOut, 2047);
            end
        end

        $display("[TB] step 2: ch1 quarter-rate frequency");
        applyStimulus(1'b1, 1'b1, 1, CFG_FREQ, 32'h4000_0000, 1'b1, '0);
        idle(24);

        $display("[TB] step 3: ch2 half-cycle phase");
        applyStimulus(1'b1, 1'b1, 2, CFG_PHASE, 32'h8000_0000, 1'b1, '0);
        idle(12);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b0, 0, 1'b0, '0, 1'b0, '0);
            if (outValid && outCh == 2'd2) begin
                checkOutput("ch2_sin", sinOut, -6);
                checkOutput("ch2_cos", cosOut, -2047);
            end
        end

        $display("[TB] step 4: commit mid-frame with write on apply cycle");
        for (int k = 0; k < NCH && mSlot != 2; k++) idle(1);
        applyStimulus(1'b1, 1'b1, 0, CFG_FREQ, 32'h2000_0000, 1'b1, '0);
        for (int k = 0; k < NCH && mSlot != 0; k++) idle(1);
        applyStimulus(1'b1, 1'b1, 3, CFG_FREQ, 32'h1000_0000, 1'b0, '0);
        idle(12);

        $display("[TB] step 5: ch1 phase restart");
        applyStimulus(1'b1, 1'b0, 0, 1'b0, '0, 1'b1, 4'b0010);
        idle(16);

        $display("[TB] step 6: stall and random traffic");
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 0, 1'b0, '0, 1'b0, '0);
        idle(8);
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom % 8) != 0, ($urandom % 4) == 0,
                          int'($urandom % NCH), 1'($urandom),
                          ($urandom % 2 == 0) ? $urandom : ($urandom << 28),
                          ($urandom % 16) == 0, 4'($urandom));
        end
        idle(8);

        $display("[TB] async reset between edges");
        #2 rstN = 1'b0;
        #1;
        checkOutput("arst_valid", outValid, 0);
        checkOutput("arst_busy", commitBusy, 0);
        checkOutput("arst_ch", outCh, 0);
        checkOutput("arst_sin", sinOut, 0);
        checkOutput("arst_cos", cosOut, 0);
        modelReset();
        #2 rstN = 1'b1;
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule

// File: doc/multi_ch_dds.md
Name: multi_ch_dds

Overview:
Time-multiplexed multi-channel quadrature DDS. NCH independent phase accumulators share one quarter-wave sine ROM and one arithmetic pipeline, one channel slot per enabled clock. Each output sample carries its channel index. Per-channel frequency and phase words are double-buffered and switch coherently at a frame boundary, with optional per-channel phase reset. Sits between the control register block and downstream mixers/modulators.

Parameters:
NCH, 4, number of channels (≥2); sample rate per channel = clk/NCH.
PW, 32, phase accumulator, frequency and phase word width.
AW, 12, full-cycle table address bits; ROM holds 2^(AW-2) quarter-wave entries.
DW, 12, signed output width; amplitude A = 2^(DW-1)-1.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous, active-low reset.
en  in  1  clock enable for accumulators, channel counter and pipeline.
cfg_we  in  1  shadow register write strobe.
cfg_ch  in  $clog2(NCH)  target channel.
cfg_sel  in  1  0 = frequency word, 1 = phase word.
cfg_data  in  PW  word written (two's complement, used modulo 2^PW).
commit  in  1  request transfer of shadow → active at next frame start.
phase_rst  in  NCH  per-channel accumulator clear mask, sampled with commit.
commit_busy  out  1  commit pending, not yet applied.
out_valid  out  1  sample valid this cycle.
out_ch  out  $clog2(NCH)  channel of current sample.
sin  out  DW  signed sine.
cos  out  DW  signed cosine.

Behaviour:
- Reset (async, rst_n=0): accumulators, shadow/active regs, ch_cnt, stage valids, commit pending and mask, out_valid, out_ch, sin, cos all 0, taking effect without a clock edge.
- ch_cnt advances 0..NCH-1 and wraps on each en=1 cycle; holds when en=0.
- Slot for channel c (cycle t, en=1): acc[c] <= acc[c]+freq_act[c] (mod 2^PW); S1 captures ph = old acc[c] + phase_act[c], ch = c, v1 = 1.
- S2: sine index = ph[PW-1 -: AW], cosine index = sine index + 2^(AW-2) (mod 2^AW). Each index splits into quadrant q (top 2 bits) and fine f (AW-2 bits); ROM address = q[0] ? ~f : f; negate flag = q[1].
- S3: registered ROM read, both addresses. ROM[k] = round(A·sin(2π(k+0.5)/2^AW)), so mirroring is exact.
- S4: output register applies negation; out_ch = c. out_valid <= en & v3. Channel c sample appears at cycle t+4.
- en=0: every stage, valid bit, accumulator and ch_cnt holds. out_valid is 0 on the following cycle; sin/cos/out_ch hold. When en returns, the held sample is emitted; no sample is lost or duplicated.
- Config write: cfg_we=1 writes shadow[cfg_ch][cfg_sel]. Writes with cfg_ch ≥ NCH are ignored. Writes never affect active regs directly.
- Commit: commit=1 sets pending, latches phase_rst mask (a later commit while pending re-latches the mask). Apply happens on the first en=1 cycle with ch_cnt==0, including a same-cycle commit. Apply copies all shadows to active, including a cfg_we write in that same cycle. Masked channels get acc cleared instead of advanced. Pending clears on apply.
- commit_busy = pending.
- The frame being issued on the apply cycle already uses the new words. Effect on output is visible 4 cycles later.

Decomposition:
- Package dds_pkg: cfg_sel encoding constants (CFG_FREQ=0, CFG_PHASE=1), pipeline latency constant LAT=4, quarter-wave ROM init function (AW, DW), channel-index width helper.
- Sub-module quarter_sine_rom: dual-read, registered output, contents from the package function, parameters AW and DW.

Test Plan:
Use NCH=4, PW=32, AW=10, DW=12 (A=2047).
1. Reset release, en=1, no config → out_valid first high 4 cycles after first slot; out_ch sequence 0,1,2,3,0,…; every sample sin=6, cos=2047.
2. Write ch1 freq=0x4000_0000, commit → ch1 sin cycles 6, 2047, -6, -2047; cos cycles 2047, -6, -2047, 6. Other channels unchanged.
3. Write ch2 phase=0x8000_0000, commit → ch2 sin=-6, cos=-2047 constant.
4. Commit asserted at ch_cnt=2 → commit_busy high until next ch_cnt=0 slot. The first sample with new words is ch0 of that frame, 4 cycles later. A cfg_we in the apply cycle is included.
5. ch1 running at 0x4000_0000, commit with phase_rst=4'b0010 → ch1 restarts at sin=6, cos=2047 on the frame after apply.
6. en toggled low 3 cycles mid-stream → out_valid low during stall; out_ch sequence continues with no gap or duplicate. rst_n pulsed low between edges → all outputs 0 immediately.
